mdp3_update_arbiter: RTL and testbench

Collects decoded book-update messages from NUM_PORTS MDP3 parser instances and serialises them onto the single order-book update port. Parsers emit a one-cycle message pulse and cannot be back-pressured, so each port gets a small FIFO. A round-robin arbiter drains the FIFOs into a registered valid/ready output stage that feeds the order book. Per-port sticky overflow flags report any update lost to a full FIFO.

---
 rtl/mdp3_update_arbiter.sv | 139 +++++++++++++
 tb/tb_mdp3_update_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdp3_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mdp3_update_arbiter
// Description : Merges decoded MDP3 book-update messages from NUM_PORTS
//               parser instances onto one order-book update port.
//               - Each port has its own small FIFO, because parsers cannot
//                 be back-pressured.
//               - A round-robin arbiter drains the FIFOs into a registered
//                 valid/ready output stage.
//               - Messages that arrive while a FIFO is full are dropped.
//                 Each drop sets a sticky per-port overflow flag.
// Ports       : clk            - clock, rising edge
//               reset          - asynchronous active-high reset
//               in_valid       - per-port one-cycle message pulse
//               in_msg         - per-port record, port i at [i*124 +: 124]
//               out_valid      - out_msg/out_port hold a message
//               out_msg        - granted record, passed through bit-exact
//               out_port       - source port index of out_msg
//               out_ready      - order book accepts the current message
//               overflow       - sticky per-port "message dropped" flags
//               clear_overflow - per-bit pulse clearing the matching flag
// Revision    : 1.0 - initial release
// ============================================================================
module mdp3_update_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int DEPTH     = 2
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_PORTS-1:0]                   in_valid,
   input  logic [NUM_PORTS*124-1:0]               in_msg,
   output logic                                   out_valid,
   output logic [123:0]                           out_msg,
   output logic [$clog2(NUM_PORTS)-1:0]           out_port,
   input  logic                                   out_ready,
   output logic [NUM_PORTS-1:0]                   overflow,
   input  logic [NUM_PORTS-1:0]                   clear_overflow
);

   localparam int c_MSG_W = 124;
   localparam int c_PW    = $clog2(NUM_PORTS);
   localparam int c_AW    = $clog2(DEPTH);

   logic [NUM_PORTS-1:0] w_empty;
   logic [NUM_PORTS-1:0] w_full;
   logic [NUM_PORTS-1:0] w_pop;
   logic [NUM_PORTS-1:0] w_push;
   logic [NUM_PORTS-1:0] w_drop;
   logic [c_MSG_W-1:0]   w_head [NUM_PORTS];

   logic [c_PW-1:0]      r_last_grant;
   logic [c_PW-1:0]      w_grant;
   logic                 w_any;
   logic                 w_load;

   // Output stage can accept a new head when empty or being drained this edge.
   assign w_any  = |(~w_empty);
   assign w_load = (!out_valid || out_ready) && w_any;

   // ------------------------------------------------------------------------
   // Per-port FIFOs. Pointers carry one extra wrap bit, so full and empty
   // can be told apart without a separate count.
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      logic [c_MSG_W-1:0] r_mem [DEPTH];
      logic [c_AW:0]      r_wptr;
      logic [c_AW:0]      r_rptr;

      assign w_empty[i] = (r_wptr == r_rptr);
      assign w_full[i]  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                          (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
      assign w_head[i]  = r_mem[r_rptr[c_AW-1:0]];
      assign w_pop[i]   = w_load && (w_grant == c_PW'(i));
      // A full FIFO still takes a push when its head leaves on the same edge.
      assign w_push[i]  = in_valid[i] && (!w_full[i] || w_pop[i]);
      assign w_drop[i]  = in_valid[i] && !w_push[i];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push[i]) r_wptr <= r_wptr + 1'b1;
            if (w_pop[i])  r_rptr <= r_rptr + 1'b1;
         end
      end

      // Storage needs no reset: the pointers alone define what is valid.
      always_ff @(posedge clk) begin
         if (w_push[i]) r_mem[r_wptr[c_AW-1:0]] <= in_msg[i*c_MSG_W +: c_MSG_W];
      end
   end

   // ------------------------------------------------------------------------
   // Round-robin search starting one past the previous winner.
   // ------------------------------------------------------------------------
   always_comb begin : p_arb
      logic found;
      int   idx;
      w_grant = r_last_grant;
      found   = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         idx = (int'(r_last_grant) + k) % NUM_PORTS;
         if (!found && !w_empty[idx]) begin
            found   = 1'b1;
            w_grant = c_PW'(idx);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registered output stage, grant history and sticky overflow flags.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_msg      <= '0;
         out_port     <= '0;
         r_last_grant <= c_PW'(NUM_PORTS - 1);
         overflow     <= '0;
      end else begin
         if (!out_valid || out_ready) begin
            if (w_any) begin
               out_valid    <= 1'b1;
               out_msg      <= w_head[w_grant];
               out_port     <= w_grant;
               r_last_grant <= w_grant;
            end else begin
               out_valid <= 1'b0;
            end
         end
         // A drop in the same cycle as a clear leaves the flag set.
         overflow <= (overflow & ~clear_overflow) | w_drop;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mdp3_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdp3_update_arbiter
// Description : Scoreboard bench for mdp3_update_arbiter (4 ports, depth 2).
//               - Stimulus pushes expected {port, record} pairs into a queue.
//               - A monitor pops the queue and compares on every transfer.
//               - Directed checks cover latency, hold under back-pressure,
//                 overflow handling and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdp3_update_arbiter;

   localparam int c_NP    = 4;
   localparam int c_DEPTH = 2;
   localparam int c_MSG_W = 124;
   localparam int c_PW    = 2;

   logic                      clk;
   logic                      reset;
   logic [c_NP-1:0]           in_valid;
   logic [c_NP*c_MSG_W-1:0]   in_msg;
   logic                      out_valid;
   logic [c_MSG_W-1:0]        out_msg;
   logic [c_PW-1:0]           out_port;
   logic                      out_ready;
   logic [c_NP-1:0]           overflow;
   logic [c_NP-1:0]           clear_overflow;

   int checks = 0;
   int errors = 0;
   logic [c_PW+c_MSG_W-1:0] exp_q [$];

   mdp3_update_arbiter #(.NUM_PORTS(c_NP), .DEPTH(c_DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_msg         (in_msg),
      .out_valid      (out_valid),
      .out_msg        (out_msg),
      .out_port       (out_port),
      .out_ready      (out_ready),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge, so out_ready is stable
   // at the falling edge: valid && ready there means a transfer next edge.
   always @(negedge clk) begin
      logic [c_PW+c_MSG_W-1:0] e;
      if (!reset && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output actual port=%0d msg=%h required none",
                     out_port, out_msg);
         end else begin
            e = exp_q.pop_front();
            if ({out_port, out_msg} !== e) begin
               errors++;
               $display("FAIL transfer actual port=%0d msg=%h required port=%0d msg=%h",
                        out_port, out_msg, e[c_PW+c_MSG_W-1 -: c_PW], e[c_MSG_W-1:0]);
            end
         end
      end
   end

   function automatic logic [c_MSG_W-1:0] mk(input logic [31:0] sec,
                                             input logic [63:0] price,
                                             input logic [15:0] qty);
      return {sec, price, qty, 8'd3, 2'd1, 2'd2};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic drive(input int p, input logic [c_MSG_W-1:0] m);
      in_valid[p] = 1'b1;
      in_msg[p*c_MSG_W +: c_MSG_W] = m;
   endtask

   task automatic expect_msg(input int p, input logic [c_MSG_W-1:0] m);
      logic [c_PW-1:0] pp;
      pp = c_PW'(p);
      exp_q.push_back({pp, m});
   endtask

   task automatic idle();
      in_valid       = '0;
      clear_overflow = '0;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      idle();
      out_ready = 1'b0;
      exp_q.delete();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL %s_drain_timeout actual pending=%0d required 0", name, exp_q.size());
      end
   endtask

   initial begin
      logic [c_MSG_W-1:0] a, b, c, d, e;
      reset = 1'b1;
      in_valid = '0;
      in_msg = '0;
      out_ready = 1'b0;
      clear_overflow = '0;
      #2;
      chk("reset_out_valid", 128'(out_valid), 128'd0);
      chk("reset_out_msg",   128'(out_msg),   128'd0);
      chk("reset_out_port",  128'(out_port),  128'd0);
      chk("reset_overflow",  128'(overflow),  128'd0);
      reset_dut();

      // Single message from port 2: two-cycle latency, then idle.
      a = mk(32'h0000ABCD, 64'h1122334455667788, 16'h0010);
      out_ready = 1'b1;
      drive(2, a);
      expect_msg(2, a);
      tick();
      idle();
      chk("single_not_yet_valid", 128'(out_valid), 128'd0);
      tick();
      chk("single_valid", 128'(out_valid), 128'd1);
      chk("single_port",  128'(out_port),  128'd2);
      chk("single_msg",   128'(out_msg),   128'(a));
      tick();
      chk("single_valid_drop", 128'(out_valid), 128'd0);
      drain("single");

      // All four ports at once after reset: grant order 0,1,2,3.
      reset_dut();
      out_ready = 1'b1;
      for (int p = 0; p < c_NP; p++) begin
         drive(p, mk(32'h100 + 32'(p), 64'hA0 + 64'(p), 16'(p)));
         expect_msg(p, mk(32'h100 + 32'(p), 64'hA0 + 64'(p), 16'(p)));
      end
      tick();
      idle();
      tick();
      for (int p = 0; p < c_NP; p++) begin
         chk("rr_port", 128'(out_port), 128'(p));
         tick();
      end
      drain("rr");
      chk("rr_overflow", 128'(overflow), 128'd0);

      // Back-pressure on port 1: output holds A, B and C fill the FIFO, D drops.
      reset_dut();
      a = mk(32'h11, 64'h1, 16'h1);
      b = mk(32'h12, 64'h2, 16'h2);
      c = mk(32'h13, 64'h3, 16'h3);
      d = mk(32'h14, 64'h4, 16'h4);
      drive(1, a); tick();
      drive(1, b); tick();
      drive(1, c); tick();
      chk("bp_hold_valid", 128'(out_valid), 128'd1);
      chk("bp_hold_msg",   128'(out_msg),   128'(a));
      chk("bp_no_drop",    128'(overflow),  128'd0);
      drive(1, d); tick();
      idle();
      chk("bp_drop", 128'(overflow), 128'b0010);
      tick(); tick();
      chk("bp_still_msg",  128'(out_msg),  128'(a));
      chk("bp_still_port", 128'(out_port), 128'd1);
      expect_msg(1, a); expect_msg(1, b); expect_msg(1, c);
      out_ready = 1'b1;
      drain("bp");

      // Port 0 full; a push in the same cycle as the release is accepted.
      reset_dut();
      a = mk(32'h21, 64'h5, 16'h5);
      b = mk(32'h22, 64'h6, 16'h6);
      c = mk(32'h23, 64'h7, 16'h7);
      d = mk(32'h24, 64'h8, 16'h8);
      drive(0, a); tick();
      drive(0, b); tick();
      drive(0, c); tick();
      idle();
      expect_msg(0, a); expect_msg(0, b); expect_msg(0, c); expect_msg(0, d);
      drive(0, d);
      out_ready = 1'b1;
      tick();
      idle();
      chk("fullpop_no_drop", 128'(overflow), 128'd0);
      drain("fullpop");
      chk("fullpop_final_ovf", 128'(overflow), 128'd0);

      // Overflow clear race on port 3: a set beats a simultaneous clear.
      reset_dut();
      a = mk(32'h31, 64'h9, 16'h9);
      b = mk(32'h32, 64'hA, 16'hA);
      c = mk(32'h33, 64'hB, 16'hB);
      d = mk(32'h34, 64'hC, 16'hC);
      e = mk(32'h35, 64'hD, 16'hD);
      drive(3, a); tick();
      drive(3, b); tick();
      drive(3, c); tick();
      drive(3, d); tick();
      idle();
      chk("race_first_drop", 128'(overflow), 128'b1000);
      drive(3, e);
      clear_overflow[3] = 1'b1;
      tick();
      idle();
      chk("race_set_wins", 128'(overflow), 128'b1000);
      clear_overflow[3] = 1'b1;
      tick();
      idle();
      chk("race_clear", 128'(overflow), 128'd0);
      expect_msg(3, a); expect_msg(3, b); expect_msg(3, c);
      out_ready = 1'b1;
      drain("race");

      // Asynchronous reset between edges with three messages buffered.
      reset_dut();
      drive(2, mk(32'h41, 64'h1, 16'h1)); tick();
      drive(2, mk(32'h42, 64'h2, 16'h2)); tick();
      drive(2, mk(32'h43, 64'h3, 16'h3)); tick();
      drive(2, mk(32'h44, 64'h4, 16'h4)); tick();
      idle();
      chk("pre_reset_ovf", 128'(overflow), 128'b0100);
      #2;
      reset = 1'b1;
      #1;
      chk("async_valid", 128'(out_valid), 128'd0);
      chk("async_ovf",   128'(overflow),  128'd0);
      chk("async_msg",   128'(out_msg),   128'd0);
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      a = mk(32'h51, 64'hE, 16'hE);
      b = mk(32'h52, 64'hF, 16'hF);
      drive(0, a);
      drive(1, b);
      expect_msg(0, a); expect_msg(1, b);
      tick();
      idle();
      drain("post_reset");
      tick(); tick();
      chk("post_reset_idle", 128'(out_valid), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual running required finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
